// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package pipelined_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Per-stage control slot. The partial sum and the skewed operand
    // remainders sit beside it in each stage because their widths depend
    // on the stage index.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_t;

    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple-carry slice built from per-bit full-adder cells.
module adder_chunk #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    // ripple the carry through W full-adder cells, noting the carry into the top bit
    always_comb begin
        logic c;
        c        = ci;
        c_msb_in = ci;
        s        = '0;
        for (int unsigned k = 0; k < W; k++) begin
            if (k == W - 1) c_msb_in = c;
            s[k] = a[k] ^ b[k] ^ c;
            c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// One CHUNK-wide slice per stage; carry is registered between stages and
// the not-yet-consumed operand bits travel forward with each beat.
// Optional feature: define PIPELINED_ADDER_OVF_EN to add the signed
// overflow output ovf.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

    if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    op_t               op;
    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic [STAGES-1:0] vld;
    logic [STAGES:0]   adv;
    logic [STAGES-1:0] c_msb;
    logic              unused_c_msb;

    assign op    = sub ? OP_SUB : OP_ADD;
    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign c_eff = (op == OP_SUB) ? 1'b1 : cin;

    // Only the top slice's MSB carry matters, and only for overflow.
    assign unused_c_msb = ^c_msb;

    // advance chain: a stage moves when it is empty or its successor moves
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int unsigned k = STAGES; k > 0; k--) begin
            adv[k-1] = !vld[k-1] || adv[k];
        end
    end

    assign in_ready = adv[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int unsigned SW = WIDTH - CHUNK * i;

        logic                   up_valid;
        logic [SW-1:0]          up_a;
        logic [SW-1:0]          up_b;
        logic                   up_c;
        logic [CHUNK-1:0]       s;
        logic                   co;
        logic [(i+1)*CHUNK-1:0] nxt_sum;
        stage_t                 st;
        logic [(i+1)*CHUNK-1:0] ps;

        if (i == 0) begin : g_src
            assign up_valid = in_valid;
            assign up_a     = a;
            assign up_b     = b_eff;
            assign up_c     = c_eff;
            assign nxt_sum  = s;
        end else begin : g_src
            assign up_valid = g_stage[i-1].st.valid;
            assign up_a     = g_stage[i-1].g_skew.rem_a;
            assign up_b     = g_stage[i-1].g_skew.rem_b;
            assign up_c     = g_stage[i-1].st.carry;
            assign nxt_sum  = {s, g_stage[i-1].ps};
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a        (up_a[CHUNK-1:0]),
            .b        (up_b[CHUNK-1:0]),
            .ci       (up_c),
            .s        (s),
            .co       (co),
            .c_msb_in (c_msb[i])
        );

        assign vld[i] = st.valid;

        // stage slot: valid follows upstream on advance; data loads only for a real beat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st <= '0;
                ps <= '0;
            end else if (adv[i]) begin
                st.valid <= up_valid;
                if (up_valid) begin
                    st.carry <= co;
                    ps       <= nxt_sum;
                end
            end
        end

        if (i < STAGES - 1) begin : g_skew
            logic [SW-CHUNK-1:0] rem_a;
            logic [SW-CHUNK-1:0] rem_b;

            // carry the unconsumed operand bits forward with the beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_a <= '0;
                    rem_b <= '0;
                end else if (adv[i] && up_valid) begin
                    rem_a <= up_a[SW-1:CHUNK];
                    rem_b <= up_b[SW-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign sum       = g_stage[STAGES-1].ps;
    assign cout      = g_stage[STAGES-1].st.carry;

`ifdef PIPELINED_ADDER_OVF_EN
    // signed overflow captured alongside the last slice's sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (adv[STAGES-1] && g_stage[STAGES-1].up_valid) begin
            ovf <= c_msb[STAGES-1] ^ g_stage[STAGES-1].co;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder. A queue-based arithmetic model
// predicts every transferred result; directed literals pin key cases.
// Define PIPELINED_ADDER_OVF_EN to exercise the ovf output as well.
module tb_pipelined_adder;

    parameter int unsigned W = 8;
    parameter int unsigned S = 2;

    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf_dut;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_in   = 0;
    int unsigned n_out  = 0;
    exp_t        q[$];

`ifdef PIPELINED_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
    logic ovf;
    assign ovf_dut = ovf;
`else
    localparam bit OVF_ON = 1'b0;
    assign ovf_dut = 1'b0;
`endif

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    // arithmetic reference: unsigned result, no-borrow flag, signed range test
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t                e;
        logic [W:0]          u;
        logic signed [W+1:0] v;
        if (s) begin
            u      = {1'b0, x} - {1'b0, y};
            e.sum  = u[W-1:0];
            e.cout = (x >= y);
            v      = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y});
        end else begin
            u      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            e.sum  = u[W-1:0];
            e.cout = u[W];
            v      = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y})
                   + $signed({{(W+1){1'b0}}, c});
        end
        e.ovf = !((v[W+1:W-1] == 3'b000) || (v[W+1:W-1] == 3'b111));
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // compare process: every meaningful output cycle against the model queue
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got sum=%h cout=%b with nothing outstanding", sum, cout);
                end else begin
                    if ((sum !== q[0].sum) || (cout !== q[0].cout) || (OVF_ON && (ovf_dut !== q[0].ovf))) begin
                        errors++;
                        $display("FAIL result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf_dut, q[0].sum, q[0].cout, q[0].ovf);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                n_in++;
            end
        end
    end

    // present a beat and hold it until accepted; returns 1 time unit after the accepting edge
    task automatic send(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv);
        int unsigned n = 0;
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got in_ready=0 expected 1 within 200 cycles", name);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, 64'(q.size()), 64'd0);
        chk({name, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    // single beat into an empty pipe; pins latency and value with literals
    task automatic lit_test(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv, input logic [W-1:0] es,
                            input logic ec, input logic eo);
        out_ready = 1'b1;
        send(name, av, bv, cv, sv);
        for (int k = 0; k < int'(S) - 1; k++) begin
            chk({name, "_early"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_sum"}, 64'(sum), 64'(es));
        chk({name, "_cout"}, 64'(cout), 64'(ec));
`ifdef PIPELINED_ADDER_OVF_EN
        chk({name, "_ovf"}, 64'(ovf), 64'(eo));
`endif
        @(posedge clk); #1;
    endtask

    task automatic stream(input string name, input int unsigned nbeats,
                          input int unsigned pv, input int unsigned pr);
        int unsigned sent = 0, guard = 0, stalls = 0, out0;
        logic took;
        out0 = n_out;
        in_valid  = ($urandom_range(99) < pv);
        a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
        out_ready = ($urandom_range(99) < pr);
        while (sent < nbeats && guard < 40 * nbeats) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (pv == 100 && pr == 100 && !in_ready) stalls++;
            @(posedge clk); #1;
            guard++;
            if (took) sent++;
            if (took || !in_valid) begin
                in_valid = (sent < nbeats) && ($urandom_range(99) < pv);
                a = W'($urandom()); b = W'($urandom());
                cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(99) < pr);
        end
        in_valid = 1'b0;
        chk({name, "_sent"}, 64'(sent), 64'(nbeats));
        if (pv == 100 && pr == 100) chk({name, "_stalls"}, 64'(stalls), 64'd0);
        drain(name);
        chk({name, "_count"}, 64'(n_out - out0), 64'(nbeats));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // carry out of the full width
        lit_test("add_wrap", '1, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
        // subtraction with and without borrow
        lit_test("sub_borrow", W'(5), W'(7), 1'b0, 1'b1, ~W'(1), 1'b0, 1'b0);
        lit_test("sub_noborrow", W'(7), W'(5), 1'b1, 1'b1, W'(2), 1'b1, 1'b0);
        lit_test("add_cin", W'(8'h12), W'(8'h34), 1'b1, 1'b0, W'(8'h47), 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_OVF_EN
        lit_test("ovf_add", MAXP, W'(1), 1'b0, 1'b0, MINN, 1'b0, 1'b1);
        lit_test("ovf_sub", MINN, W'(1), 1'b0, 1'b1, MAXP, 1'b1, 1'b1);
        lit_test("ovf_none", W'(8'h10), W'(8'h20), 1'b0, 1'b0, W'(8'h30), 1'b0, 1'b0);
`endif

        // backpressure: S beats fill the pipe, the next one waits
        out_ready = 1'b0;
        base = n_in;
        fork
            begin
                repeat (S + 2) @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_accepted", 64'(n_in - base), 64'(S));
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k <= int'(S); k++) begin
            send("stall", W'(k * 37 + 3), W'(k * 11 + 1), 1'(k), 1'(k >> 1));
        end
        drain("stall");

        stream("full_rate", 256, 100, 100);
        stream("random_hs", 256, 60, 55);

        // asynchronous reset with beats in flight
        out_ready = 1'b0;
        a = W'(8'h21); b = W'(8'h43); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = W'(8'h65); b = W'(8'h07);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_sum", 64'(sum), 64'd0);
        chk("midreset_cout", 64'(cout), 64'd0);
`ifdef PIPELINED_ADDER_OVF_EN
        chk("midreset_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        chk("postreset_in_ready", 64'(in_ready), 64'd1);
        chk("postreset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        lit_test("postreset_beat", W'(8'h0F), W'(8'h01), 1'b1, 1'b0, W'(8'h11), 1'b0, 1'b0);
        drain("postreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
